// File: rtl/toysram_2r1w_array_if.sv
// Request/response bundle for the 2-read/1-write toysram array.
// The controller side uses the master modport and the array uses the slave modport.
interface toysram_2r1w_array_if #(
  parameter int unsigned AW   = 6,
  parameter int unsigned BITS = 24
);
  logic            rd0_enable;
  logic [AW-1:0]   rd0_addr;
  logic            rd0_valid;
  logic [BITS-1:0] rd0_data;
  logic            rd1_enable;
  logic [AW-1:0]   rd1_addr;
  logic            rd1_valid;
  logic [BITS-1:0] rd1_data;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data;
  logic            init_busy;

  modport master (
    output rd0_enable, rd0_addr, rd1_enable, rd1_addr, wr_enable, wr_addr, wr_data,
    input  rd0_valid, rd0_data, rd1_valid, rd1_data, init_busy
  );

  modport slave (
    input  rd0_enable, rd0_addr, rd1_enable, rd1_addr, wr_enable, wr_addr, wr_data,
    output rd0_valid, rd0_data, rd1_valid, rd1_data, init_busy
  );
endinterface

// File: rtl/toysram_2r1w_array.sv
// 2-read/1-write toysram array with a one-stage request pipe, a dot-AND read bitline
// and a power-on init engine. Define TOYSRAM_WRITE_BYPASS_EN to forward same-cycle writes.
module toysram_2r1w_array #(
  parameter int unsigned   AW       = 6,
  parameter int unsigned   BITS     = 24,
  parameter logic [BITS-1:0] INIT_VAL = '0
) (
  input logic                 clk,
  input logic                 reset,
  toysram_2r1w_array_if.slave bus
);
  localparam int unsigned WORDS = 2 ** AW;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  logic            state_q;
  logic [AW-1:0]   init_ptr_q;
  logic            init_busy;

  logic            rd0_en_q, rd1_en_q, wr_en_q;
  logic [AW-1:0]   rd0_addr_q, rd1_addr_q, wr_addr_q;
  logic [BITS-1:0] wr_data_q;

  logic [WORDS-1:0] rwl0, rwl1, wwl;
  logic [BITS-1:0]  rbl0_n, rbl1_n;
  logic [BITS-1:0]  rd0_word, rd1_word;
  logic [BITS-1:0]  mem [WORDS];

  logic            rd0_valid_q, rd1_valid_q;
  logic [BITS-1:0] rd0_data_q, rd1_data_q;

  assign init_busy = (state_q == ST_INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_ptr_q <= init_ptr_q + 1'b1;
      if (&init_ptr_q) state_q <= ST_READY;
    end
  end

  // Stage 0: requests are dropped while the init engine owns the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd0_en_q   <= 1'b0;
      rd1_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd0_addr_q <= '0;
      rd1_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rd0_en_q   <= bus.rd0_enable & ~init_busy;
      rd1_en_q   <= bus.rd1_enable & ~init_busy;
      wr_en_q    <= bus.wr_enable & ~init_busy;
      rd0_addr_q <= bus.rd0_addr;
      rd1_addr_q <= bus.rd1_addr;
      wr_addr_q  <= bus.wr_addr;
      wr_data_q  <= bus.wr_data;
    end
  end

  // Stage 1: word-line decode and negative-active dot-AND bitlines.
  always_comb begin
    rwl0 = '0;
    rwl1 = '0;
    wwl  = '0;
    rwl0[rd0_addr_q] = rd0_en_q;
    rwl1[rd1_addr_q] = rd1_en_q;
    wwl[wr_addr_q]   = wr_en_q;
  end

  always_comb begin
    rbl0_n = '1;
    rbl1_n = '1;
    for (int w = 0; w < WORDS; w++) begin
      rbl0_n = rbl0_n & ~(mem[w] & {BITS{rwl0[w]}});
      rbl1_n = rbl1_n & ~(mem[w] & {BITS{rwl1[w]}});
    end
  end

`ifdef TOYSRAM_WRITE_BYPASS_EN
  always_comb begin
    rd0_word = (wr_en_q && (wr_addr_q == rd0_addr_q)) ? wr_data_q : ~rbl0_n;
    rd1_word = (wr_en_q && (wr_addr_q == rd1_addr_q)) ? wr_data_q : ~rbl1_n;
  end
`else
  always_comb begin
    rd0_word = ~rbl0_n;
    rd1_word = ~rbl1_n;
  end
`endif

  // Storage has no reset; only the init engine or a decoded write line changes it.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WORDS; w++) begin
      if (!reset) begin
        if (init_busy) begin
          if (init_ptr_q == AW'(w)) mem[w] <= INIT_VAL;
        end else if (wwl[w]) begin
          mem[w] <= wr_data_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
    end else begin
      rd0_valid_q <= rd0_en_q;
      rd1_valid_q <= rd1_en_q;
      if (rd0_en_q) rd0_data_q <= rd0_word;
      if (rd1_en_q) rd1_data_q <= rd1_word;
    end
  end

  assign bus.rd0_valid = rd0_valid_q;
  assign bus.rd1_valid = rd1_valid_q;
  assign bus.rd0_data  = rd0_data_q;
  assign bus.rd1_data  = rd1_data_q;
  assign bus.init_busy = init_busy;

`ifndef SYNTHESIS
  wwl_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(wwl));
`endif

endmodule
